// File: rtl/swervolf_sevseg_pkg.sv
// Shared definitions for the SweRVolf seven-segment display controller:
// register word indices, reset constants and the hex-to-segment table.
package swervolf_sevseg_pkg;

    // Wishbone word indices (i_wb_adr[5:2]); words 0..7 hold digit bytes
    localparam logic [3:0] REG_DIGIT_LAST = 4'd7;
    localparam logic [3:0] REG_CTRL       = 4'd8;
    localparam logic [3:0] REG_EN_MASK    = 4'd9;
    localparam logic [3:0] REG_BLINK_MASK = 4'd10;
    localparam logic [3:0] REG_HEX_MASK   = 4'd11;
    localparam logic [3:0] REG_STATUS     = 4'd12;

    // Reset values
    localparam logic [7:0] RST_DIGIT  = 8'h00;
    localparam logic       RST_EN     = 1'b0;
    localparam logic [3:0] RST_BRIGHT = 4'hF;

    // Control register fields
    typedef struct packed {
        logic [3:0] bright;
        logic       en;
    } ctrl_t;

    // Hex nibble to segments {a,b,c,d,e,f,g}, 1 = lit
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/swervolf_sevseg_scan.sv
// Scan timebase: prescaler, digit index, frame counter and blink phase.
// Free-running after reset and never touched by bus activity.
module swervolf_sevseg_scan #(
    parameter int unsigned N_DIGITS  = 8,
    parameter int unsigned CLK_DIV   = 1024,
    parameter int unsigned BLINK_DIV = 64,
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic [IW-1:0] idx,
    output logic [3:0]    pwm_slice,
    output logic          phase
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] presc;
    logic [FW-1:0] frame;
    logic          presc_tc;
    logic          idx_tc;
    logic          frame_tc;

    assign presc_tc  = (presc == PW'(CLK_DIV - 1));
    assign idx_tc    = (idx == IW'(N_DIGITS - 1));
    assign frame_tc  = (frame == FW'(BLINK_DIV - 1));
    assign pwm_slice = presc[PW-1 -: 4];

    // Advance prescaler every cycle, digit on prescaler wrap, frame on digit wrap
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc <= '0;
            idx   <= '0;
            frame <= '0;
            phase <= 1'b0;
        end else begin
            presc <= presc + PW'(1);
            if (presc_tc) begin
                if (idx_tc) begin
                    idx <= '0;
                    if (frame_tc) begin
                        frame <= '0;
                        phase <= ~phase;
                    end else begin
                        frame <= frame + FW'(1);
                    end
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/swervolf_sevseg_ctrl.sv
// Wishbone-mapped, time-multiplexed seven-segment display controller.
// Optional hex decoding per digit is enabled by SWERVOLF_SEVSEG_HEX_DECODE_EN;
// without it segments are always raw and HEX_MASK reads as zero.
module swervolf_sevseg_ctrl
    import swervolf_sevseg_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 8,
    parameter int unsigned CLK_DIV        = 1024,
    parameter int unsigned BLINK_DIV      = 64,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [5:0]          i_wb_adr,
    input  logic [31:0]         i_wb_dat,
    input  logic [3:0]          i_wb_sel,
    input  logic                i_wb_we,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    output logic [31:0]         o_wb_rdt,
    output logic                o_wb_ack,
    output logic [N_DIGITS-1:0] o_an,
    output logic [7:0]          o_seg
);

    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [7:0]          digit [N_DIGITS];
    ctrl_t               ctrl;
    logic [N_DIGITS-1:0] en_mask;
    logic [N_DIGITS-1:0] blink_mask;
    logic [N_DIGITS-1:0] hex_mask;

    logic [IW-1:0]       idx;
    logic [3:0]          pwm_slice;
    logic                phase;

    logic                bus_req;
    logic                wr_en;
    logic [3:0]          word;
    logic [31:0]         rd_data;

    logic                lit;
    logic [7:0]          seg_lit;
    logic [N_DIGITS-1:0] an_on;
    logic                unused_adr;

    assign bus_req    = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr_en      = bus_req & i_wb_we;
    assign word       = i_wb_adr[5:2];
    assign unused_adr = &{1'b0, i_wb_adr[1:0]};

    swervolf_sevseg_scan #(
        .N_DIGITS  (N_DIGITS),
        .CLK_DIV   (CLK_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) u_scan (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .idx       (idx),
        .pwm_slice (pwm_slice),
        .phase     (phase)
    );

    // Register writes, each byte gated by its lane select
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned d = 0; d < N_DIGITS; d++) begin
                digit[d] <= RST_DIGIT;
            end
            ctrl.en     <= RST_EN;
            ctrl.bright <= RST_BRIGHT;
            en_mask     <= '1;
            blink_mask  <= '0;
        end else if (wr_en) begin
            for (int unsigned d = 0; d < N_DIGITS; d++) begin
                if (word == 4'(d / 4) && i_wb_sel[d % 4]) begin
                    digit[d] <= i_wb_dat[8*(d % 4) +: 8];
                end
            end
            if (word == REG_CTRL && i_wb_sel[0]) begin
                ctrl.en     <= i_wb_dat[0];
                ctrl.bright <= i_wb_dat[7:4];
            end
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                if (word == REG_EN_MASK && i_wb_sel[i / 8]) begin
                    en_mask[i] <= i_wb_dat[i];
                end
                if (word == REG_BLINK_MASK && i_wb_sel[i / 8]) begin
                    blink_mask[i] <= i_wb_dat[i];
                end
            end
        end
    end

`ifdef SWERVOLF_SEVSEG_HEX_DECODE_EN
    // Hex-decode mask, writable only when decoding is built in
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hex_mask <= '0;
        end else if (wr_en && word == REG_HEX_MASK) begin
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                if (i_wb_sel[i / 8]) begin
                    hex_mask[i] <= i_wb_dat[i];
                end
            end
        end
    end
`else
    assign hex_mask = '0;
`endif

    // Read multiplexer; unmapped words and absent digits return zero
    always_comb begin
        rd_data = '0;
        if (word <= REG_DIGIT_LAST) begin
            for (int unsigned d = 0; d < N_DIGITS; d++) begin
                if (word == 4'(d / 4)) begin
                    rd_data[8*(d % 4) +: 8] = digit[d];
                end
            end
        end else begin
            case (word)
                REG_CTRL:       rd_data = {24'b0, ctrl.bright, 3'b0, ctrl.en};
                REG_EN_MASK:    rd_data = 32'(en_mask);
                REG_BLINK_MASK: rd_data = 32'(blink_mask);
                REG_HEX_MASK:   rd_data = 32'(hex_mask);
                REG_STATUS:     rd_data = {23'b0, phase, 3'b0, 5'(idx)};
                default:        rd_data = '0;
            endcase
        end
    end

    // Single-wait-state acknowledge with registered read data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            o_wb_ack <= bus_req;
            if (bus_req) begin
                o_wb_rdt <= rd_data;
            end
        end
    end

    // Decide whether the current digit is lit and what it shows
    always_comb begin
        seg_lit = digit[idx];
        if (hex_mask[idx]) begin
            seg_lit = {digit[idx][7], hex2seg(digit[idx][3:0])};
        end
        lit = ctrl.en & en_mask[idx] & ~(blink_mask[idx] & phase)
            & (pwm_slice <= ctrl.bright);
        an_on = '0;
        if (lit) begin
            an_on[idx] = 1'b1;
        end
    end

    // Output flops: anode and segments change together on the same edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_an  <= {N_DIGITS{AN_ACTIVE_LOW}};
            o_seg <= {8{SEG_ACTIVE_LOW}};
        end else begin
            o_an  <= an_on ^ {N_DIGITS{AN_ACTIVE_LOW}};
            o_seg <= (lit ? seg_lit : 8'h00) ^ {8{SEG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_swervolf_sevseg_ctrl.sv
// Scoreboard bench for swervolf_sevseg_ctrl: a cycle-count model predicts the
// pins each clock and bus reads are predicted at issue; monitors compare.
module tb_swervolf_sevseg_ctrl;

    localparam int unsigned N    = 8;
    localparam int unsigned CDIV = 16;
    localparam int unsigned BDIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        we  = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] rdt;
    logic        ack;
    logic [7:0]  an;
    logic [7:0]  seg;

    swervolf_sevseg_ctrl #(
        .N_DIGITS       (N),
        .CLK_DIV        (CDIV),
        .BLINK_DIV      (BDIV),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_wb_adr (adr),
        .i_wb_dat (dat),
        .i_wb_sel (sel),
        .i_wb_we  (we),
        .i_wb_cyc (cyc),
        .i_wb_stb (stb),
        .o_wb_rdt (rdt),
        .o_wb_ack (ack),
        .o_an     (an),
        .o_seg    (seg)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Shadow of the programmer-visible registers
    logic [7:0]  m_digit [N];
    logic        m_en;
    logic [3:0]  m_bright;
    logic [7:0]  m_enm;
    logic [7:0]  m_blm;
    logic [7:0]  m_hexm;
    int unsigned m_cnt  = 0;
    bit          m_live = 1'b0;

`ifdef SWERVOLF_SEVSEG_HEX_DECODE_EN
    logic [6:0] hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
`endif

    typedef struct {
        bit          is_rd;
        logic [3:0]  word;
        logic [31:0] exp;
    } bus_t;

    logic [15:0] pin_q [$];
    bus_t        bus_q [$];
    logic [15:0] mon_e;
    bus_t        mon_b;

    // Expected {an,seg} from the number of clocks elapsed since reset
    function automatic logic [15:0] expect_pins(input int unsigned c);
        int unsigned slot, d, frame, ph, level;
        bit          lit;
        logic [7:0]  s;
        slot  = c / CDIV;
        d     = slot % N;
        frame = slot / N;
        ph    = (frame / BDIV) % 2;
        level = (c % CDIV) * 16 / CDIV;
        lit   = m_en && m_enm[d] && !(m_blm[d] && ph == 1) && level <= m_bright;
        s     = m_digit[d];
`ifdef SWERVOLF_SEVSEG_HEX_DECODE_EN
        if (m_hexm[d]) s = {s[7], hex_tab[s[3:0]]};
`endif
        if (!lit) return 16'hFFFF;
        return {~(8'd1 << d), ~s};
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] w);
        logic [31:0] r;
        int unsigned slot;
        r = '0;
        if (w < 4'd8) begin
            for (int k = 0; k < 4; k++) begin
                if (int'(w) * 4 + k < N) r[8*k +: 8] = m_digit[int'(w) * 4 + k];
            end
        end else if (w == 4'd8) begin
            r = {24'b0, m_bright, 3'b0, m_en};
        end else if (w == 4'd9) begin
            r = {24'b0, m_enm};
        end else if (w == 4'd10) begin
            r = {24'b0, m_blm};
        end else if (w == 4'd11) begin
            r = {24'b0, m_hexm};
        end else if (w == 4'd12) begin
            slot = m_cnt / CDIV;
            r = {23'b0, 1'(((slot / N) / BDIV) % 2), 3'b0, 5'(slot % N)};
        end
        return r;
    endfunction

    task automatic apply_write(input logic [3:0] w, input logic [31:0] d, input logic [3:0] s);
        if (w < 4'd8) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k] && int'(w) * 4 + k < N) m_digit[int'(w) * 4 + k] = d[8*k +: 8];
            end
        end else if (w == 4'd8) begin
            if (s[0]) begin
                m_en     = d[0];
                m_bright = d[7:4];
            end
        end else if (w == 4'd9) begin
            if (s[0]) m_enm = d[7:0];
        end else if (w == 4'd10) begin
            if (s[0]) m_blm = d[7:0];
        end else if (w == 4'd11) begin
`ifdef SWERVOLF_SEVSEG_HEX_DECODE_EN
            if (s[0]) m_hexm = d[7:0];
`endif
        end
    endtask

    // Reference model: predict the pins produced by each clock edge
    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            m_live = 1'b1;
            pin_q.push_back(16'hFFFF);
        end else if (m_live) begin
            pin_q.push_back(expect_pins(m_cnt));
            m_cnt++;
        end
    end

    // Monitor: compare pins every cycle and read data on every acknowledge
    always @(negedge clk) begin
        if (pin_q.size() > 0) begin
            mon_e = pin_q.pop_front();
            tests++;
            if ({an, seg} !== mon_e) begin
                fails++;
                $display("FAIL pins t=%0t got an=%h seg=%h want an=%h seg=%h",
                         $time, an, seg, mon_e[15:8], mon_e[7:0]);
            end
        end
        if (ack === 1'b1) begin
            if (bus_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack t=%0t got ack=1 want no ack", $time);
            end else begin
                mon_b = bus_q.pop_front();
                if (mon_b.is_rd) begin
                    tests++;
                    if (rdt !== mon_b.exp) begin
                        fails++;
                        $display("FAIL read_w%0d t=%0t got %h want %h", mon_b.word, $time, rdt, mon_b.exp);
                    end
                end
            end
        end
    end

    task automatic bus(input bit wr, input logic [3:0] w, input logic [31:0] d, input logic [3:0] s);
        bus_t b;
        @(negedge clk);
        adr = {w, 2'b00};
        dat = d;
        sel = s;
        we  = wr;
        cyc = 1'b1;
        stb = 1'b1;
        b.is_rd = !wr;
        b.word  = w;
        b.exp   = wr ? 32'h0 : model_read(w);
        bus_q.push_back(b);
        @(posedge clk);
        #1;
        tests++;
        if (ack !== 1'b1) begin
            fails++;
            $display("FAIL ack_latency w=%0d got ack=%b want 1", w, ack);
        end
        if (wr) apply_write(w, d, s);
        @(posedge clk);
        #1;
        tests++;
        if (ack !== 1'b0) begin
            fails++;
            $display("FAIL ack_back_to_back w=%0d got ack=%b want 0", w, ack);
        end
        @(negedge clk);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) m_digit[i] = 8'h00;
        m_en     = 1'b0;
        m_bright = 4'hF;
        m_enm    = 8'hFF;
        m_blm    = 8'h00;
        m_hexm   = 8'h00;
        bus_q.delete();
        tests++;
        if (ack !== 1'b0) begin
            fails++;
            $display("FAIL reset_ack got %b want 0", ack);
        end
        tests++;
        if (an !== 8'hFF) begin
            fails++;
            $display("FAIL reset_an got %h want ff", an);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [3:0]  w;
        logic [31:0] d;
        int unsigned op;
        bit          found;

        do_reset();
        bus(1'b0, 4'd8, '0, 4'hF);
        bus(1'b0, 4'd13, '0, 4'hF);
        bus(1'b0, 4'd9, '0, 4'hF);

        bus(1'b1, 4'd0, 32'h04030201, 4'hF);
        bus(1'b1, 4'd8, 32'h000000F1, 4'hF);
        idle(300);
        bus(1'b1, 4'd8, 32'h00000031, 4'hF);
        idle(64);
        bus(1'b1, 4'd10, 32'h00000001, 4'hF);
        bus(1'b1, 4'd8, 32'h000000F1, 4'hF);
        idle(600);
        bus(1'b1, 4'd11, 32'h00000001, 4'hF);
        bus(1'b1, 4'd0, 32'h0000008A, 4'h1);
        bus(1'b0, 4'd11, '0, 4'hF);
        bus(1'b0, 4'd0, '0, 4'hF);
        idle(200);

        // Reset in the middle of slot 5
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if ((m_cnt / CDIV) % N == 5 && m_cnt % CDIV == 7) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL slot5_wait got timeout want slot 5 reached");
        end
        do_reset();
        bus(1'b0, 4'd8, '0, 4'hF);
        bus(1'b0, 4'd0, '0, 4'hF);
        bus(1'b0, 4'd12, '0, 4'hF);

        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 19);
            w  = 4'($urandom_range(0, 15));
            d  = $urandom;
            if (op < 12) begin
                if (w == 4'd8 && $urandom_range(0, 4) != 0) d[0] = 1'b1;
                bus(1'b1, w, d, 4'($urandom_range(0, 15)));
            end else if (op < 19) begin
                bus(1'b0, w, '0, 4'hF);
            end else begin
                do_reset();
            end
            idle($urandom_range(0, 200));
        end

        idle(4);
        tests++;
        if (bus_q.size() != 0) begin
            fails++;
            $display("FAIL pending_acks got %0d want 0", bus_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
